// File: rtl/mem_arbiter_if.sv
// Bus bundle between the 6502 core, the DMA/loader master and the unified memory.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  // CPU port
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rdy;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  // DMA / loader port
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  // Memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdy, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdy, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU has default priority, DMA gets bounded bursts
// and is forced in after a run of denied cycles.
module mem_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 8,
  parameter int MAX_DMA_BURST = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic         ph1,
  input  logic         reset_b,
  mem_arbiter_if.slave bus
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int BW = (MAX_DMA_BURST > 1) ? $clog2(MAX_DMA_BURST) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_DMA_BURST - 1);

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  owner_t        owner;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          cpu_rvalid_p1;
  logic          dma_rvalid_p1;

  logic          owner_cpu;
  logic          sel_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          issue;
  logic          issue_rd;

  always_comb begin
    owner_cpu = (owner == OWN_CPU);
    sel_req   = owner_cpu ? bus.cpu_req   : bus.dma_req;
    sel_we    = owner_cpu ? bus.cpu_we    : bus.dma_we;
    sel_addr  = owner_cpu ? bus.cpu_addr  : bus.dma_addr;
    sel_wdata = owner_cpu ? bus.cpu_wdata : bus.dma_wdata;
    // Handshakes are gated by reset_b so they drop the instant reset asserts.
    issue     = reset_b & sel_req;
    issue_rd  = issue & ~sel_we;
  end

  assign bus.cpu_rdy    = reset_b &  owner_cpu;
  assign bus.dma_gnt    = reset_b & ~owner_cpu;
  assign bus.mem_en     = issue;
  assign bus.mem_we     = issue & sel_we;
  assign bus.mem_addr   = sel_addr;
  assign bus.mem_wdata  = sel_wdata;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.cpu_rvalid = cpu_rvalid_p1;
  assign bus.dma_rvalid = dma_rvalid_p1;

  // ---- stage p0 -> p1: ownership, counters, read-return valids ----
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      owner         <= OWN_CPU;
      starve_cnt    <= '0;
      burst_cnt     <= '0;
      cpu_rvalid_p1 <= 1'b0;
      dma_rvalid_p1 <= 1'b0;
    end else begin
      cpu_rvalid_p1 <= issue_rd &  owner_cpu;
      dma_rvalid_p1 <= issue_rd & ~owner_cpu;
      unique case (owner)
        OWN_CPU: begin
          // Limit check uses the pre-increment count; a falling dma_req wins.
          if (bus.dma_req && (!bus.cpu_req || starve_cnt == STARVE_MAX)) begin
            owner      <= OWN_DMA;
            starve_cnt <= '0;
            burst_cnt  <= '0;
          end else if (bus.dma_req) begin
            if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
          end else begin
            starve_cnt <= '0;
          end
        end
        OWN_DMA: begin
          // Always hand back to the CPU for at least one cycle after a burst.
          if (!bus.dma_req || burst_cnt == BURST_LAST) begin
            owner     <= OWN_CPU;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: owner <= OWN_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, CPU read, DMA bursts, starvation,
// early burst end, simultaneous limit/drop and reset in mid-burst.
module tb_mem_arbiter;

  logic ph1;
  logic reset_b;
  int   n_cmp;
  int   n_mis;

  logic [7:0] ram [0:65535];

  mem_arbiter_if #(.AW(16), .DW(8)) bus ();

  mem_arbiter #(
    .AW(16), .DW(8), .MAX_DMA_BURST(4), .STARVE_LIMIT(8)
  ) dut (
    .ph1     (ph1),
    .reset_b (reset_b),
    .bus     (bus)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  // Synchronous single-port memory, one cycle read latency.
  always @(posedge ph1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0003] = 8'h22;
    bus.mem_rdata = 8'h00;
    reset_b       = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = 16'h0000;
    bus.dma_wdata = 8'h00;

    // Reset state
    #1;
    chk("rst_cpu_rdy", bus.cpu_rdy, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    @(negedge ph1); reset_b = 1'b1;
    #1;
    chk("rel_cpu_rdy", bus.cpu_rdy, 1);
    chk("rel_dma_gnt", bus.dma_gnt, 0);

    // CPU read of 0x0003
    @(negedge ph1); bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0003;
    #1;
    chk("cr_mem_en", bus.mem_en, 1);
    chk("cr_mem_we", bus.mem_we, 0);
    chk("cr_mem_addr", bus.mem_addr, 16'h0003);
    @(negedge ph1); bus.cpu_req = 1'b0;
    #1;
    chk("cr_rvalid", bus.cpu_rvalid, 1);
    chk("cr_rdata", bus.cpu_rdata, 8'h22);
    chk("cr_dma_rvalid", bus.dma_rvalid, 0);
    @(negedge ph1);
    #1;
    chk("cr_rvalid_drop", bus.cpu_rvalid, 0);

    // DMA write burst A0..A3 to 0x0100..0x0103, CPU idle
    @(negedge ph1);
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0100; bus.dma_wdata = 8'hA0;
    #1;
    chk("dw_wait_gnt", bus.dma_gnt, 0);
    chk("dw_wait_en", bus.mem_en, 0);
    for (int b = 0; b < 4; b++) begin
      @(negedge ph1);
      bus.dma_addr  = 16'h0100 + 16'(b);
      bus.dma_wdata = 8'hA0 + 8'(b);
      #1;
      chk("dw_gnt", bus.dma_gnt, 1);
      chk("dw_cpu_rdy", bus.cpu_rdy, 0);
      chk("dw_mem_we", bus.mem_we, 1);
      chk("dw_mem_addr", bus.mem_addr, 16'h0100 + b);
    end
    // Turnaround bubble, then read back
    @(negedge ph1); bus.dma_we = 1'b0; bus.dma_addr = 16'h0100;
    #1;
    chk("bubble_gnt", bus.dma_gnt, 0);
    chk("bubble_cpu_rdy", bus.cpu_rdy, 1);
    chk("bubble_mem_en", bus.mem_en, 0);
    for (int b = 0; b < 4; b++) begin
      @(negedge ph1);
      bus.dma_addr = 16'h0100 + 16'(b);
      #1;
      chk("dr_gnt", bus.dma_gnt, 1);
      chk("dr_mem_we", bus.mem_we, 0);
      chk("dr_rvalid", bus.dma_rvalid, (b != 0));
      if (b != 0) chk("dr_rdata", bus.dma_rdata, 8'hA0 + b - 1);
    end
    @(negedge ph1); bus.dma_req = 1'b0;
    #1;
    chk("dr_end_gnt", bus.dma_gnt, 0);
    chk("dr_last_rvalid", bus.dma_rvalid, 1);
    chk("dr_last_rdata", bus.dma_rdata, 8'hA3);
    chk("dr_cpu_rvalid", bus.cpu_rvalid, 0);
    @(negedge ph1);
    #1;
    chk("dr_rvalid_drop", bus.dma_rvalid, 0);

    // Starvation: both requesting, 9 CPU + 4 DMA cycles, period 13
    for (int k = 0; k < 26; k++) begin
      @(negedge ph1);
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010; bus.dma_req = 1'b1; bus.dma_addr = 16'h0200;
      #1;
      chk("st_gnt", bus.dma_gnt, ((k % 13) >= 9));
      chk("st_cpu_rdy", bus.cpu_rdy, ((k % 13) < 9));
      chk("st_mem_addr", bus.mem_addr, ((k % 13) >= 9) ? 16'h0200 : 16'h0010);
    end

    // Early end after 2 beats
    @(negedge ph1); bus.cpu_req = 1'b0; bus.dma_req = 1'b1;
    #1;
    chk("ee_wait_gnt", bus.dma_gnt, 0);
    @(negedge ph1);
    #1;
    chk("ee_beat0", bus.dma_gnt, 1);
    @(negedge ph1);
    #1;
    chk("ee_beat1", bus.dma_gnt, 1);
    @(negedge ph1); bus.dma_req = 1'b0;
    #1;
    chk("ee_drop_gnt", bus.dma_gnt, 1);
    chk("ee_drop_en", bus.mem_en, 0);
    @(negedge ph1); bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    #1;
    chk("ee_back_gnt", bus.dma_gnt, 0);
    chk("ee_back_rdy", bus.cpu_rdy, 1);
    // Fresh starve and burst counts: 9 CPU cycles, 4 full beats, bubble
    for (int k = 1; k < 14; k++) begin
      @(negedge ph1);
      #1;
      chk("ee_cnt_gnt", bus.dma_gnt, (k >= 9 && k < 13));
    end

    // Simultaneous: limit reached in the cycle dma_req falls
    @(negedge ph1); bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    #1;
    chk("sim_idle_gnt", bus.dma_gnt, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge ph1); bus.cpu_req = 1'b1; bus.dma_req = (k != 8);
      #1;
      chk("sim_build_gnt", bus.dma_gnt, 0);
    end
    @(negedge ph1); bus.dma_req = 1'b1;
    #1;
    chk("sim_nogrant", bus.dma_gnt, 0);
    chk("sim_cpu_rdy", bus.cpu_rdy, 1);
    for (int k = 1; k < 10; k++) begin
      @(negedge ph1);
      #1;
      chk("sim_restart_gnt", bus.dma_gnt, (k == 9));
    end

    // Reset during DMA beat 2
    @(negedge ph1);
    #1;
    chk("mr_beat1_gnt", bus.dma_gnt, 1);
    @(negedge ph1);
    #1;
    chk("mr_beat2_gnt", bus.dma_gnt, 1);
    chk("mr_beat2_rvalid", bus.dma_rvalid, 1);
    #1 reset_b = 1'b0;
    #1;
    chk("mr_gnt", bus.dma_gnt, 0);
    chk("mr_mem_en", bus.mem_en, 0);
    chk("mr_mem_we", bus.mem_we, 0);
    chk("mr_cpu_rdy", bus.cpu_rdy, 0);
    chk("mr_rvalid", bus.dma_rvalid, 0);
    @(negedge ph1); reset_b = 1'b1; bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    #1;
    chk("mr_rel_rdy", bus.cpu_rdy, 1);
    chk("mr_rel_gnt", bus.dma_gnt, 0);
    chk("mr_rel_rvalid", bus.dma_rvalid, 0);
    @(negedge ph1);
    #1;
    chk("mr_rel_rvalid2", bus.dma_rvalid, 0);
    chk("mr_rel_cpu_rvalid", bus.cpu_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
